// File: rtl/gate_stimulus_checker.sv
// Clocked exerciser for a small combinational gate: walks every input vector in
// ascending order, samples the gate output once per vector and tallies mismatches.
module gate_stimulus_checker #(
   parameter int N_IN        = 2,
   parameter int HOLD_CYCLES = 2,
   parameter int GATE_FN     = 0,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [N_IN-1:0]  stim,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [N_IN-1:0]  first_err_vec,
   output logic             first_err_valid,
   output logic [1:0]       dbg_state
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [N_IN-1:0]  STIM_LAST = '1;
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [N_IN-1:0]  stim_q;
   logic [HW-1:0]    hold_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [ERR_W-1:0] err_q;
   logic [N_IN-1:0]  fev_q;
   logic             fevv_q;

   logic             golden_d;
   logic             mismatch_d;
   logic [ERR_W-1:0] err_d;

   always_comb begin
      golden_d = 1'b0;
      case (GATE_FN)
         0:       golden_d = &stim_q;
         1:       golden_d = |stim_q;
         2:       golden_d = ^stim_q;
         3:       golden_d = ~&stim_q;
         default: golden_d = &stim_q;
      endcase
   end

   // Saturating count so a long run of failures never wraps back to zero.
   assign mismatch_d = (dut_out != golden_d);
   assign err_d      = (mismatch_d && (err_q != ERR_MAX)) ? err_q + ERR_W'(1) : err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         stim_q  <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fev_q   <= '0;
         fevv_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= ST_RUN;
                  stim_q  <= '0;
                  hold_q  <= '0;
                  busy_q  <= 1'b1;
                  err_q   <= '0;
                  pass_q  <= 1'b0;
                  fevv_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (hold_q == HOLD_LAST) begin
                  err_q <= err_d;
                  if (mismatch_d && !fevv_q) begin
                     fev_q  <= stim_q;
                     fevv_q <= 1'b1;
                  end
                  // pass is published with the done pulse, using the final count.
                  if (stim_q == STIM_LAST) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_d == '0);
                  end else begin
                     stim_q <= stim_q + N_IN'(1);
                     hold_q <= '0;
                  end
               end else begin
                  hold_q <= hold_q + HW'(1);
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign stim            = stim_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign first_err_vec   = fev_q;
   assign first_err_valid = fevv_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_gate_stimulus_checker.sv
// Bench for gate_stimulus_checker: three instances (AND, NAND golden, 3-input saturating)
// driven by truth-table gate models, checked against a vector-counting reference model.
module tb_gate_stimulus_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic [3:0] tbl_a = 4'b1000, tbl_b = 4'b0111;
   logic [7:0] tbl_c = 8'h80;

   logic [1:0] stim_a, stim_b, fev_a, fev_b, dbg_a, dbg_b, dbg_c;
   logic [2:0] stim_c, fev_c;
   logic [7:0] err_a, err_b;
   logic [1:0] err_c;
   logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic pass_a, pass_b, pass_c, fevv_a, fevv_b, fevv_c;
   logic dout_a, dout_b, dout_c;

   // The gate under test is a truth table indexed by the stimulus vector.
   assign dout_a = tbl_a[stim_a];
   assign dout_b = tbl_b[stim_b];
   assign dout_c = tbl_c[stim_c];

   gate_stimulus_checker #(.N_IN(2), .HOLD_CYCLES(2), .GATE_FN(0), .ERR_W(8)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .dut_out(dout_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
      .first_err_vec(fev_a), .first_err_valid(fevv_a), .dbg_state(dbg_a));

   gate_stimulus_checker #(.N_IN(2), .HOLD_CYCLES(2), .GATE_FN(3), .ERR_W(8)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .dut_out(dout_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
      .first_err_vec(fev_b), .first_err_valid(fevv_b), .dbg_state(dbg_b));

   gate_stimulus_checker #(.N_IN(3), .HOLD_CYCLES(1), .GATE_FN(0), .ERR_W(2)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .stim(stim_c), .dut_out(dout_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
      .first_err_vec(fev_c), .first_err_valid(fevv_c), .dbg_state(dbg_c));

   int checks = 0;
   int failures = 0;

   logic [2:0] exp_q[$];
   logic [2:0] obs_stim_q[$];
   bit         obs_busy_q[$];
   bit         obs_done_q[$];

   // ---------------- reference model ----------------
   function automatic bit golden(input int fn, input int n, input int v);
      int top;
      top = (1 << n) - 1;
      case (fn)
         0:       return v == top;
         1:       return v != 0;
         2:       return ($countones(v) % 2) == 1;
         default: return v != top;
      endcase
   endfunction

   function automatic int model_errs(input int fn, input int n, input logic [7:0] tbl, input int maxv);
      int cnt;
      cnt = 0;
      for (int v = 0; v < (1 << n); v++)
         if (tbl[v] != golden(fn, n, v)) cnt++;
      return (cnt > maxv) ? maxv : cnt;
   endfunction

   function automatic int model_first(input int fn, input int n, input logic [7:0] tbl);
      for (int v = 0; v < (1 << n); v++)
         if (tbl[v] != golden(fn, n, v)) return v;
      return -1;
   endfunction

   // Expected stim for sample k after the start edge: each vector repeated hold times,
   // then the last vector stays put.
   task automatic build_exp(input int n, input int hold, input int samples);
      exp_q.delete();
      for (int k = 0; k < samples; k++)
         exp_q.push_back((k < (1 << n) * hold) ? 3'(k / hold) : 3'((1 << n) - 1));
   endtask

   // ---------------- driver ----------------
   task automatic set_start(input int which, input logic v);
      case (which)
         0:       start_a = v;
         1:       start_b = v;
         default: start_c = v;
      endcase
   endtask

   task automatic run(input int which, input int samples, input int repulse_at, input bit hold_start);
      obs_stim_q.delete();
      obs_busy_q.delete();
      obs_done_q.delete();
      @(negedge clk);
      set_start(which, 1'b1);
      @(negedge clk);
      if (!hold_start) set_start(which, 1'b0);
      for (int k = 0; k < samples; k++) begin
         case (which)
            0: begin obs_stim_q.push_back(3'(stim_a)); obs_busy_q.push_back(busy_a); obs_done_q.push_back(done_a); end
            1: begin obs_stim_q.push_back(3'(stim_b)); obs_busy_q.push_back(busy_b); obs_done_q.push_back(done_b); end
            default: begin obs_stim_q.push_back(stim_c); obs_busy_q.push_back(busy_c); obs_done_q.push_back(done_c); end
         endcase
         if (!hold_start) set_start(which, (k == repulse_at) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
      set_start(which, 1'b0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({stim_a, busy_a, done_a, pass_a, err_a, fev_a, fevv_a} !== '0) begin
         failures++;
         $display("FAIL reset_a: got stim=%0d busy=%0b done=%0b pass=%0b err=%0d fev=%0d fevv=%0b, required all zero",
                  stim_a, busy_a, done_a, pass_a, err_a, fev_a, fevv_a);
      end
      checks++;
      if ({stim_c, busy_c, done_c, pass_c, err_c, fev_c, fevv_c} !== '0) begin
         failures++;
         $display("FAIL reset_c: got stim=%0d busy=%0b done=%0b pass=%0b err=%0d fev=%0d fevv=%0b, required all zero",
                  stim_c, busy_c, done_c, pass_c, err_c, fev_c, fevv_c);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_clean_and;
      tbl_a = 4'b1000;
      run(0, 12, -1, 1'b0);
      build_exp(2, 2, 12);
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (obs_stim_q[k] !== exp_q[k] || obs_busy_q[k] !== (k < 8) || obs_done_q[k] !== (k == 8)) begin
            failures++;
            $display("FAIL clean_trace k=%0d: got stim=%0d busy=%0b done=%0b, required stim=%0d busy=%0b done=%0b",
                     k, obs_stim_q[k], obs_busy_q[k], obs_done_q[k], exp_q[k], k < 8, k == 8);
         end
      end
      checks++;
      if (pass_a !== 1'b1 || err_a !== 8'd0 || fevv_a !== 1'b0) begin
         failures++;
         $display("FAIL clean_result: got pass=%0b err=%0d fevv=%0b, required pass=1 err=0 fevv=0", pass_a, err_a, fevv_a);
      end
   endtask

   task automatic test_stuck0;
      tbl_a = 4'b0000;
      run(0, 10, -1, 1'b0);
      checks++;
      if (err_a !== 8'(model_errs(0, 2, {4'b0, tbl_a}, 255)) || fev_a !== 2'(model_first(0, 2, {4'b0, tbl_a}))
          || fevv_a !== 1'b1 || pass_a !== 1'b0) begin
         failures++;
         $display("FAIL stuck0: got err=%0d fev=%0d fevv=%0b pass=%0b, required err=1 fev=3 fevv=1 pass=0",
                  err_a, fev_a, fevv_a, pass_a);
      end
   endtask

   task automatic test_nand;
      tbl_a = 4'b0111;
      run(0, 10, -1, 1'b0);
      checks++;
      if (err_a !== 8'(model_errs(0, 2, {4'b0, tbl_a}, 255)) || fev_a !== 2'd0 || fevv_a !== 1'b1 || pass_a !== 1'b0) begin
         failures++;
         $display("FAIL nand_vs_and: got err=%0d fev=%0d fevv=%0b pass=%0b, required err=4 fev=0 fevv=1 pass=0",
                  err_a, fev_a, fevv_a, pass_a);
      end
      tbl_b = 4'b0111;
      run(1, 10, -1, 1'b0);
      checks++;
      if (pass_b !== 1'b1 || err_b !== 8'd0 || fevv_b !== 1'b0) begin
         failures++;
         $display("FAIL nand_vs_nand: got pass=%0b err=%0d fevv=%0b, required pass=1 err=0 fevv=0", pass_b, err_b, fevv_b);
      end
   endtask

   task automatic test_random_gates;
      int e, f;
      for (int it = 0; it < 8; it++) begin
         tbl_a = 4'($urandom);
         tbl_b = 4'($urandom_range(0, 15));
         run(0, 10, -1, 1'b0);
         e = model_errs(0, 2, {4'b0, tbl_a}, 255);
         f = model_first(0, 2, {4'b0, tbl_a});
         checks++;
         if (err_a !== 8'(e) || pass_a !== (e == 0) || fevv_a !== (f >= 0) || (f >= 0 && fev_a !== 2'(f))) begin
            failures++;
            $display("FAIL random_a tbl=%b: got err=%0d pass=%0b fevv=%0b fev=%0d, required err=%0d first=%0d",
                     tbl_a, err_a, pass_a, fevv_a, fev_a, e, f);
         end
         run(1, 10, -1, 1'b0);
         e = model_errs(3, 2, {4'b0, tbl_b}, 255);
         f = model_first(3, 2, {4'b0, tbl_b});
         checks++;
         if (err_b !== 8'(e) || pass_b !== (e == 0) || fevv_b !== (f >= 0) || (f >= 0 && fev_b !== 2'(f))) begin
            failures++;
            $display("FAIL random_b tbl=%b: got err=%0d pass=%0b fevv=%0b fev=%0d, required err=%0d first=%0d",
                     tbl_b, err_b, pass_b, fevv_b, fev_b, e, f);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit seen;
      tbl_a = 4'b1000;
      run(0, 12, 3, 1'b0);
      build_exp(2, 2, 12);
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (obs_stim_q[k] !== exp_q[k] || obs_done_q[k] !== (k == 8)) begin
            failures++;
            $display("FAIL repulse_trace k=%0d: got stim=%0d done=%0b, required stim=%0d done=%0b",
                     k, obs_stim_q[k], obs_done_q[k], exp_q[k], k == 8);
         end
      end
      run(0, 12, -1, 1'b1);
      checks++;
      if (obs_done_q[8] !== 1'b1 || obs_busy_q[9] !== 1'b0 || obs_stim_q[9] !== 3'd3
          || obs_busy_q[10] !== 1'b1 || obs_stim_q[10] !== 3'd0) begin
         failures++;
         $display("FAIL held_start: got done8=%0b busy9=%0b stim9=%0d busy10=%0b stim10=%0d, required 1 0 3 1 0",
                  obs_done_q[8], obs_busy_q[9], obs_stim_q[9], obs_busy_q[10], obs_stim_q[10]);
      end
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (done_a) seen = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!seen || pass_a !== 1'b1) begin
         failures++;
         $display("FAIL held_second_run: got done_seen=%0b pass=%0b, required 1 1", seen, pass_a);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int done_seen;
      tbl_a = 4'b1111;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (stim_a !== 2'd2 || err_a !== 8'd2) begin
         failures++;
         $display("FAIL mid_before_rst: got stim=%0d err=%0d, required stim=2 err=2", stim_a, err_a);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || stim_a !== 2'd0 || err_a !== 8'd0 || done_a !== 1'b0 || fevv_a !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst: got busy=%0b stim=%0d err=%0d done=%0b fevv=%0b, required all zero",
                  busy_a, stim_a, err_a, done_a, fevv_a);
      end
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (done_a) done_seen++;
         @(negedge clk);
      end
      checks++;
      if (done_seen != 0) begin
         failures++;
         $display("FAIL mid_no_done: got %0d done pulses, required 0", done_seen);
      end
      tbl_a = 4'b1000;
      run(0, 10, -1, 1'b0);
      checks++;
      if (obs_done_q[8] !== 1'b1 || pass_a !== 1'b1 || err_a !== 8'd0) begin
         failures++;
         $display("FAIL mid_rerun: got done8=%0b pass=%0b err=%0d, required 1 1 0", obs_done_q[8], pass_a, err_a);
      end
   endtask

   task automatic test_saturate;
      int e, f;
      tbl_c = 8'hFF;
      run(2, 11, -1, 1'b0);
      build_exp(3, 1, 11);
      for (int k = 0; k < 11; k++) begin
         checks++;
         if (obs_stim_q[k] !== exp_q[k] || obs_busy_q[k] !== (k < 8) || obs_done_q[k] !== (k == 8)) begin
            failures++;
            $display("FAIL sat_trace k=%0d: got stim=%0d busy=%0b done=%0b, required stim=%0d busy=%0b done=%0b",
                     k, obs_stim_q[k], obs_busy_q[k], obs_done_q[k], exp_q[k], k < 8, k == 8);
         end
      end
      checks++;
      if (err_c !== 2'(model_errs(0, 3, tbl_c, 3)) || fev_c !== 3'd0 || fevv_c !== 1'b1 || pass_c !== 1'b0) begin
         failures++;
         $display("FAIL saturate: got err=%0d fev=%0d fevv=%0b pass=%0b, required err=3 fev=0 fevv=1 pass=0",
                  err_c, fev_c, fevv_c, pass_c);
      end
      for (int it = 0; it < 6; it++) begin
         tbl_c = 8'($urandom);
         run(2, 10, -1, 1'b0);
         e = model_errs(0, 3, tbl_c, 3);
         f = model_first(0, 3, tbl_c);
         checks++;
         if (err_c !== 2'(e) || pass_c !== (e == 0) || fevv_c !== (f >= 0) || (f >= 0 && fev_c !== 3'(f))) begin
            failures++;
            $display("FAIL random_c tbl=%b: got err=%0d pass=%0b fevv=%0b fev=%0d, required err=%0d first=%0d",
                     tbl_c, err_c, pass_c, fevv_c, fev_c, e, f);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_and();
      test_stuck0();
      test_nand();
      test_random_gates();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
